// File: rtl/rand_arbiter.sv
// Shares one xorshift PRNG between N_REQ requesters and streams fixed-point samples.
// Build option: define RAND_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.

`ifndef F_LEN
`define F_LEN 15
`endif
`ifndef I_LEN_W
`define I_LEN_W 1
`endif
`ifndef N_LEN_W
`define N_LEN_W (`I_LEN_W + `F_LEN)
`endif

// state  | meaning
// IDLE   | no burst; arbitrate among eligible requesters
// PRIME  | grant held, PRNG advanced once before the first sample
// STREAM | one sample per cycle, cnt_q samples remaining including the current one
module rand_arbiter #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 32,
    parameter int LEN_W = 5,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*LEN_W-1:0]  req_len_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    rng_run_o,
    input  logic [WIDTH-1:0]        rng_q_i,
    output logic [`N_LEN_W-1:0]     dout_o,
    output logic                    dout_valid_o,
    output logic [ID_W-1:0]         dout_id_o,
    output logic [N_REQ-1:0]        done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ID_W-1:0]  id_q, id_d;

    logic [N_REQ-1:0] elig;
    logic             any_elig;
    logic [ID_W-1:0]  win_id;
    logic [LEN_W-1:0] win_len;
    logic [N_REQ-1:0] id_oh;
    logic             last_sample;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_i[i] && (req_len_i[i*LEN_W +: LEN_W] != '0);
        end
    end

    assign any_elig = |elig;

`ifdef RAND_ARB_FIXED_PRI_EN
    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        win_id = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_id = ID_W'(i);
            end
        end
    end
`else
    // ptr_q is where the next search starts: one past the previous winner.
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;
    int              idx;

    always_comb begin
        win_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && elig[idx]) begin
                found  = 1'b1;
                win_id = ID_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && any_elig) begin
            if (win_id == ID_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_id + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        win_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_len = req_len_i[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        id_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            id_oh[i] = (id_q == ID_W'(i));
        end
    end

    assign last_sample = (cnt_q == LEN_W'(1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        gnt_o        = '0;
        rng_run_o    = 1'b0;
        dout_valid_o = 1'b0;
        done_o       = '0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d = PRIME;
                    cnt_d   = win_len;
                    id_d    = win_id;
                end
            end
            PRIME: begin
                gnt_o     = id_oh;
                rng_run_o = 1'b1;
                state_d   = STREAM;
            end
            STREAM: begin
                gnt_o        = id_oh;
                dout_valid_o = 1'b1;
                rng_run_o    = !last_sample;
                cnt_d        = cnt_q - LEN_W'(1);
                if (last_sample) begin
                    done_o  = id_oh;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    assign dout_id_o = id_q;

    // Sign bit is the draw's bit F_LEN, replicated across the integer field.
    assign dout_o = {{`I_LEN_W{rng_q_i[`F_LEN]}}, rng_q_i[`F_LEN-1:0]};

    logic unused_rng_hi;
    assign unused_rng_hi = ^rng_q_i[WIDTH-1:`F_LEN+1];

endmodule

// File: tb/tb_rand_arbiter.sv
// Directed self-checking bench for rand_arbiter; expected order depends on RAND_ARB_FIXED_PRI_EN.

`ifndef F_LEN
`define F_LEN 15
`endif
`ifndef I_LEN_W
`define I_LEN_W 1
`endif
`ifndef N_LEN_W
`define N_LEN_W (`I_LEN_W + `F_LEN)
`endif

module tb_rand_arbiter;

    logic                clk;
    logic                rst;
    logic [2:0]          req;
    logic [14:0]         req_len;
    logic [2:0]          gnt;
    logic                rng_run;
    logic [31:0]         rng_q;
    logic [`N_LEN_W-1:0] dout;
    logic                dout_valid;
    logic [1:0]          dout_id;
    logic [2:0]          done;

    int checks = 0;
    int errors = 0;

    rand_arbiter #(
        .N_REQ(3),
        .WIDTH(32),
        .LEN_W(5),
        .ID_W (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .req_len_i   (req_len),
        .gnt_o       (gnt),
        .rng_run_o   (rng_run),
        .rng_q_i     (rng_q),
        .dout_o      (dout),
        .dout_valid_o(dout_valid),
        .dout_id_o   (dout_id),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        req     = '0;
        req_len = '0;
        rng_q   = 32'h1234_5678;
        step();
        step();
        checks++;
        if ({gnt, rng_run, dout_valid, done} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want %b", {gnt, rng_run, dout_valid, done}, 8'b0);
        end
        checks++;
        if (dout_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_dout_id got %0d want 0", dout_id);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle_gnt got %b want 000", gnt);
        end
    endtask

    // req=001, len0=4
    task automatic test_single();
        logic [2:0] eg, ed;
        logic       er, ev;
        req_len      = '0;
        req_len[4:0] = 5'd4;
        req          = 3'b001;
        for (int k = 1; k <= 6; k++) begin
            step();
            eg = (k <= 5) ? 3'b001 : 3'b000;
            er = (k <= 4);
            ev = (k >= 2 && k <= 5);
            ed = (k == 5) ? 3'b001 : 3'b000;
            checks++;
            if ({gnt, rng_run, dout_valid, done} !== {eg, er, ev, ed}) begin
                errors++;
                $display("FAIL single_k%0d got gnt=%b run=%b dv=%b done=%b want gnt=%b run=%b dv=%b done=%b",
                         k, gnt, rng_run, dout_valid, done, eg, er, ev, ed);
            end
            if (ev) begin
                checks++;
                if (dout_id !== 2'd0) begin
                    errors++;
                    $display("FAIL single_id_k%0d got %0d want 0", k, dout_id);
                end
            end
            if (k == 5) req = 3'b000;
        end
    endtask

    // req=011, len0=len1=2, from a fresh reset
    task automatic test_two();
        logic [2:0] eg[8];
        logic [2:0] ed[8];
        logic       er[8];
        logic       ev[8];
        logic [1:0] ei[8];
        eg = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
        ed = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ev = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ei = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        rst = 1'b1;
        step();
        rst          = 1'b0;
        req_len      = '0;
        req_len[4:0] = 5'd2;
        req_len[9:5] = 5'd2;
        req          = 3'b011;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if ({gnt, rng_run, dout_valid, done} !== {eg[k-1], er[k-1], ev[k-1], ed[k-1]}) begin
                errors++;
                $display("FAIL two_k%0d got gnt=%b run=%b dv=%b done=%b want gnt=%b run=%b dv=%b done=%b",
                         k, gnt, rng_run, dout_valid, done, eg[k-1], er[k-1], ev[k-1], ed[k-1]);
            end
            if (ev[k-1]) begin
                checks++;
                if (dout_id !== ei[k-1]) begin
                    errors++;
                    $display("FAIL two_id_k%0d got %0d want %0d", k, dout_id, ei[k-1]);
                end
            end
            if (k == 3) req = 3'b010;
            if (k == 7) req = 3'b000;
        end
    endtask

    // req=100 held through done, then req=111 held
    task automatic test_rerequest();
        logic [2:0] order[4];
`ifdef RAND_ARB_FIXED_PRI_EN
        order = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        req_len        = '0;
        req_len[14:10] = 5'd2;
        req            = 3'b100;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 3) begin
                checks++;
                if (done !== 3'b100) begin
                    errors++;
                    $display("FAIL rereq_done1 got %b want 100", done);
                end
            end
            if (k == 4) begin
                checks++;
                if (gnt !== 3'b000) begin
                    errors++;
                    $display("FAIL rereq_gap got %b want 000", gnt);
                end
            end
            if (k == 5) begin
                checks++;
                if (gnt !== 3'b100 || dout_id !== 2'd2) begin
                    errors++;
                    $display("FAIL rereq_regrant got gnt=%b id=%0d want gnt=100 id=2", gnt, dout_id);
                end
            end
        end
        req_len = {5'd1, 5'd1, 5'd1};
        req     = 3'b111;
        step();
        for (int b = 0; b < 4; b++) begin
            step();
            checks++;
            if (gnt !== order[b] || rng_run !== 1'b1 || dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL order_gnt_b%0d got gnt=%b run=%b dv=%b want gnt=%b run=1 dv=0",
                         b, gnt, rng_run, dout_valid, order[b]);
            end
            step();
            checks++;
            if (done !== order[b] || dout_valid !== 1'b1 || rng_run !== 1'b0) begin
                errors++;
                $display("FAIL order_done_b%0d got done=%b dv=%b run=%b want done=%b dv=1 run=0",
                         b, done, dout_valid, rng_run, order[b]);
            end
            if (b == 3) req = 3'b000;
            step();
            checks++;
            if (gnt !== 3'b000) begin
                errors++;
                $display("FAIL order_gap_b%0d got %b want 000", b, gnt);
            end
        end
    endtask

    // zero-length request is never granted; len=1 gives exactly one sample
    task automatic test_zero_len();
        int samples;
        req_len = '0;
        req     = 3'b010;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if ({gnt, dout_valid, done} !== 7'b0) begin
                errors++;
                $display("FAIL zerolen_k%0d got gnt=%b dv=%b done=%b want all zero", k, gnt, dout_valid, done);
            end
        end
        req_len[9:5] = 5'd1;
        samples = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (dout_valid === 1'b1) samples++;
            if (k == 2) begin
                checks++;
                if (done !== 3'b010 || dout_id !== 2'd1) begin
                    errors++;
                    $display("FAIL len1_done got done=%b id=%0d want done=010 id=1", done, dout_id);
                end
                req = 3'b000;
            end
        end
        checks++;
        if (samples != 1) begin
            errors++;
            $display("FAIL len1_samples got %0d want 1", samples);
        end
    endtask

    // reset mid-STREAM aborts, next request restarts at PRIME
    task automatic test_reset_mid();
        req_len      = '0;
        req_len[4:0] = 5'd8;
        req          = 3'b001;
        step();
        step();
        step();
        checks++;
        if (dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_streaming got dv=%b want 1", dout_valid);
        end
        rst = 1'b1;
        req = 3'b000;
        step();
        checks++;
        if ({gnt, rng_run, dout_valid, done} !== 8'b0) begin
            errors++;
            $display("FAIL midrst_abort got %b want %b", {gnt, rng_run, dout_valid, done}, 8'b0);
        end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if ({done, dout_valid} !== 4'b0) begin
                errors++;
                $display("FAIL midrst_quiet_k%0d got done=%b dv=%b want 000 0", k, done, dout_valid);
            end
        end
        req_len[4:0] = 5'd2;
        req          = 3'b001;
        step();
        checks++;
        if (gnt !== 3'b001 || rng_run !== 1'b1 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_prime got gnt=%b run=%b dv=%b want gnt=001 run=1 dv=0", gnt, rng_run, dout_valid);
        end
        step();
        step();
        checks++;
        if (done !== 3'b001) begin
            errors++;
            $display("FAIL midrst_done got %b want 001", done);
        end
        req = 3'b000;
        step();
    endtask

    task automatic test_dout();
        logic [31:0]         vin[3];
        logic [`N_LEN_W-1:0] vexp[3];
        vin  = '{32'h0001_8000, 32'hFFFF_7FFF, 32'h0000_C001};
        vexp = '{16'h8000, 16'h7FFF, 16'hC001};
        for (int i = 0; i < 3; i++) begin
            rng_q = vin[i];
            #1;
            checks++;
            if (dout !== vexp[i]) begin
                errors++;
                $display("FAIL dout_%0d got %h want %h", i, dout, vexp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_rerequest();
        test_zero_len();
        test_reset_mid();
        test_dout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
